// File: rtl/alu_sequencer_pkg.sv
// Shared constants for alu_sequencer: opcodes, instruction field offsets, cond codes, FSM states.
// Optional feature macro used by the top: COND_EXEC_EN.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_SUM = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;

    // Field offsets above the WIDTH-bit immediate at the bottom of the word
    localparam int RS2_OFS    = 0;
    localparam int RS1_OFS    = 2;
    localparam int RD_OFS     = 4;
    localparam int COND_OFS   = 6;
    localparam int OP_OFS     = 8;
    localparam int INSTR_XTRA = 12;

    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_Z  = 2'b01;
    localparam logic [1:0] COND_NZ = 2'b10;
    localparam logic [1:0] COND_C  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_SUM) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// alu_regfile: 4 x WIDTH register file, two async operand reads, async debug read,
// one synchronous write port, synchronous active-high clear.
module alu_regfile #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       i_rs1_addr,
    input  logic [1:0]       i_rs2_addr,
    input  logic [1:0]       i_dbg_addr,
    output logic [WIDTH-1:0] o_rs1_data,
    output logic [WIDTH-1:0] o_rs2_data,
    output logic [WIDTH-1:0] o_dbg_data,
    input  logic             i_we,
    input  logic [1:0]       i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data
);

    logic [3:0][WIDTH-1:0] r_regs;

    always_ff @(posedge CLK) begin
        if (RST)
            r_regs <= '0;
        else if (i_we)
            r_regs[i_wr_addr] <= i_wr_data;
    end

    assign o_rs1_data = r_regs[i_rs1_addr];
    assign o_rs2_data = r_regs[i_rs2_addr];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches instructions over valid/ready, drives the alu through EXEC/WB and writes back.
// Define COND_EXEC_EN to gate instructions on the latched flags via the cond field.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH+INSTR_XTRA-1:0] INSTR,
    input  logic                       INSTR_VALID,
    output logic                       INSTR_READY,
    output logic                       ALU_EN,
    output logic                       ALU_OE,
    output logic [3:0]                 ALU_OPCODE,
    output logic [WIDTH-1:0]           ALU_A,
    output logic [WIDTH-1:0]           ALU_B,
    input  logic [WIDTH-1:0]           ALU_RESULT,
    input  logic                       ALU_CF,
    input  logic                       ALU_ZF,
    input  logic                       ALU_SF,
    input  logic                       ALU_OF,
    output logic [3:0]                 FLAGS,
    output logic                       BUSY,
    input  logic [1:0]                 DBG_ADDR,
    output logic [WIDTH-1:0]           DBG_DATA
);

    state_t                        r_state;
    logic [WIDTH+INSTR_XTRA-1:0]   r_ir;
    logic [3:0]                    r_flags;
    logic                          r_alu_en;
    logic                          r_alu_oe;
    logic [3:0]                    r_opcode;
    logic [WIDTH-1:0]              r_a;
    logic [WIDTH-1:0]              r_b;
    logic                          r_busy;

    logic [3:0]       w_op;
    logic [1:0]       w_cond;
    logic [1:0]       w_rd;
    logic [1:0]       w_ir_rd;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_rs1_data;
    logic [WIDTH-1:0] w_rs2_data;
    logic             w_accept;
    logic             w_cond_ok;
    logic             w_in_wb;
    logic             w_we;
    logic [1:0]       w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_unused;

    assign w_op    = INSTR[WIDTH+OP_OFS +: 4];
    assign w_cond  = INSTR[WIDTH+COND_OFS +: 2];
    assign w_rd    = INSTR[WIDTH+RD_OFS +: 2];
    assign w_imm   = INSTR[WIDTH-1:0];
    assign w_ir_rd = r_ir[WIDTH+RD_OFS +: 2];

    assign INSTR_READY = (r_state == ST_IDLE) && !RST;
    assign w_accept    = INSTR_VALID && INSTR_READY;
    assign w_in_wb     = (r_state == ST_WB);

`ifdef COND_EXEC_EN
    always_comb begin
        w_cond_ok = 1'b1;
        case (w_cond)
            COND_Z:  w_cond_ok = r_flags[2];
            COND_NZ: w_cond_ok = !r_flags[2];
            COND_C:  w_cond_ok = r_flags[3];
            default: w_cond_ok = 1'b1;
        endcase
    end
`else
    assign w_cond_ok = 1'b1;
`endif

    // Write port is shared: LDI at its accept edge, ALU result at the end of WB
    assign w_we      = !RST && (w_in_wb || (w_accept && w_cond_ok && (w_op == OP_LDI)));
    assign w_wr_addr = w_in_wb ? w_ir_rd : w_rd;
    assign w_wr_data = w_in_wb ? ALU_RESULT : w_imm;

    alu_regfile #(.WIDTH(WIDTH)) u_regfile (
        .CLK        (CLK),
        .RST        (RST),
        .i_rs1_addr (INSTR[WIDTH+RS1_OFS +: 2]),
        .i_rs2_addr (INSTR[WIDTH+RS2_OFS +: 2]),
        .i_dbg_addr (DBG_ADDR),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .o_dbg_data (DBG_DATA),
        .i_we       (w_we),
        .i_wr_addr  (w_wr_addr),
        .i_wr_data  (w_wr_data)
    );

    // Operands are captured at accept and held through EXEC and WB so the alu recaptures the same result
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_ir     <= '0;
            r_flags  <= '0;
            r_alu_en <= 1'b0;
            r_alu_oe <= 1'b0;
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ir <= INSTR;
                        if (w_cond_ok && is_alu_op(w_op)) begin
                            r_state  <= ST_EXEC;
                            r_alu_en <= 1'b1;
                            r_opcode <= w_op;
                            r_a      <= w_rs1_data;
                            r_b      <= w_rs2_data;
                            r_busy   <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_state  <= ST_WB;
                    r_alu_oe <= 1'b1;
                end
                ST_WB: begin
                    r_state  <= ST_IDLE;
                    r_flags  <= {ALU_CF, ALU_ZF, ALU_SF, ALU_OF};
                    r_alu_en <= 1'b0;
                    r_alu_oe <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ALU_EN     = r_alu_en;
    assign ALU_OE     = r_alu_oe;
    assign ALU_OPCODE = r_opcode;
    assign ALU_A      = r_a;
    assign ALU_B      = r_b;
    assign FLAGS      = r_flags;
    assign BUSY       = r_busy;

    assign w_unused = ^{r_ir, w_cond};

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural alu model on the ALU ports.
module tb_alu_sequencer;

    localparam int W = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W+11:0] INSTR = '0;
    logic          INSTR_VALID = 1'b0;
    logic          INSTR_READY;
    logic          ALU_EN, ALU_OE;
    logic [3:0]    ALU_OPCODE;
    logic [W-1:0]  ALU_A, ALU_B, ALU_RESULT;
    logic          ALU_CF, ALU_ZF, ALU_SF, ALU_OF;
    logic [3:0]    FLAGS;
    logic          BUSY;
    logic [1:0]    DBG_ADDR = 2'd0;
    logic [W-1:0]  DBG_DATA;

    int n_tests = 0;
    int n_fail  = 0;

    alu_sequencer #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_RESULT(ALU_RESULT), .ALU_CF(ALU_CF), .ALU_ZF(ALU_ZF), .ALU_SF(ALU_SF), .ALU_OF(ALU_OF),
        .FLAGS(FLAGS), .BUSY(BUSY), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
    );

    always #5 CLK = ~CLK;

    // Behavioural alu: captures on EN, drives result/flags only while OE
    logic [W-1:0] m_res;
    logic         m_cf, m_of;
    logic [W:0]   m_t;
    always @(posedge CLK) begin
        if (ALU_EN) begin
            m_cf <= 1'b0;
            m_of <= 1'b0;
            case (ALU_OPCODE)
                4'h2: begin
                    m_t   = {1'b0, ALU_A} + {1'b0, ALU_B};
                    m_res <= m_t[W-1:0];
                    m_cf  <= m_t[W];
                    m_of  <= (ALU_A[W-1] == ALU_B[W-1]) && (m_t[W-1] != ALU_A[W-1]);
                end
                4'h3: begin
                    m_t   = {1'b0, ALU_A} - {1'b0, ALU_B};
                    m_res <= m_t[W-1:0];
                    m_cf  <= (ALU_A < ALU_B);
                    m_of  <= (ALU_A[W-1] != ALU_B[W-1]) && (m_t[W-1] != ALU_A[W-1]);
                end
                4'h4: m_res <= ALU_A & ALU_B;
                4'h5: m_res <= ALU_A | ALU_B;
                4'h6: m_res <= ALU_A ^ ALU_B;
                4'h7: m_res <= ~ALU_A;
                default: m_res <= '0;
            endcase
        end
    end
    assign ALU_RESULT = ALU_OE ? m_res : 'z;
    assign ALU_CF     = ALU_OE ? m_cf : 1'b0;
    assign ALU_ZF     = ALU_OE ? (m_res == '0) : 1'bx;
    assign ALU_SF     = ALU_OE ? m_res[W-1] : 1'b0;
    assign ALU_OF     = ALU_OE ? m_of : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+11:0] mk(input logic [3:0] op, input logic [1:0] c, input logic [1:0] rd,
                                         input logic [1:0] s1, input logic [1:0] s2, input logic [W-1:0] imm);
        return {op, c, rd, s1, s2, imm};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [W+11:0] ins, output int waited);
        INSTR       = ins;
        INSTR_VALID = 1'b1;
        waited      = 0;
        while (!INSTR_READY && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (waited >= 20) chk("accept_timeout", 32'(waited), 32'd0);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic reg_is(input string tag, input logic [1:0] a, input logic [W-1:0] exp);
        DBG_ADDR = a;
        #1;
        chk(tag, 32'(DBG_DATA), 32'(exp));
    endtask

    // READY must stay low whenever the sequencer is busy; OE only together with EN
    always @(negedge CLK) begin
        if (!RST && BUSY) chk("ready_while_busy", 32'(INSTR_READY), 32'd0);
        if (ALU_OE) chk("oe_implies_en", 32'(ALU_EN), 32'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (2) @(negedge CLK);
        chk("ready_in_reset", 32'(INSTR_READY), 32'd0);
        RST = 1'b0;
        #1;
        chk("rst_ready", 32'(INSTR_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_en_oe", 32'({ALU_EN, ALU_OE}), 32'd0);
        chk("rst_opcode", 32'(ALU_OPCODE), 32'd0);
        chk("rst_ab", 32'({ALU_A, ALU_B}), 32'd0);
        chk("rst_flags", 32'(FLAGS), 32'd0);
        for (int i = 0; i < 4; i++) reg_is("rst_reg", 2'(i), 8'h00);
        @(negedge CLK);

        // Basic SUM with per-cycle timing
        send(mk(4'h1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h05), w);
        chk("ldi_ready", 32'(INSTR_READY), 32'd1);
        chk("ldi_busy", 32'(BUSY), 32'd0);
        send(mk(4'h1, 2'b00, 2'd2, 2'd0, 2'd0, 8'h03), w);
        reg_is("ldi_r1", 2'd1, 8'h05);
        reg_is("ldi_r2", 2'd2, 8'h03);
        send(mk(4'h2, 2'b00, 2'd0, 2'd1, 2'd2, 8'h00), w);
        chk("exec_en_oe", 32'({ALU_EN, ALU_OE}), 32'b10);
        chk("exec_busy", 32'(BUSY), 32'd1);
        chk("exec_opcode", 32'(ALU_OPCODE), 32'h2);
        chk("exec_ab", 32'({ALU_A, ALU_B}), 32'h0503);
        @(negedge CLK);
        chk("wb_en_oe", 32'({ALU_EN, ALU_OE}), 32'b11);
        chk("wb_ab_held", 32'({ALU_A, ALU_B}), 32'h0503);
        @(negedge CLK);
        chk("done_en_oe", 32'({ALU_EN, ALU_OE}), 32'b00);
        chk("done_busy", 32'(BUSY), 32'd0);
        chk("done_ready", 32'(INSTR_READY), 32'd1);
        reg_is("sum_r0", 2'd0, 8'h08);
        chk("sum_flags", 32'(FLAGS), 32'b0000);

        // Carry and zero
        send(mk(4'h1, 2'b00, 2'd1, 2'd0, 2'd0, 8'hFF), w);
        send(mk(4'h1, 2'b00, 2'd2, 2'd0, 2'd0, 8'h01), w);
        send(mk(4'h2, 2'b00, 2'd3, 2'd1, 2'd2, 8'h00), w);
        wait_idle();
        reg_is("carry_r3", 2'd3, 8'h00);
        chk("carry_flags", 32'(FLAGS), 32'b1100);

        // Signed overflow, then borrow with rd overlapping a source
        send(mk(4'h1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h7F), w);
        send(mk(4'h1, 2'b00, 2'd2, 2'd0, 2'd0, 8'h01), w);
        send(mk(4'h2, 2'b00, 2'd0, 2'd1, 2'd2, 8'h00), w);
        wait_idle();
        reg_is("ovf_r0", 2'd0, 8'h80);
        chk("ovf_flags", 32'(FLAGS), 32'b0011);
        send(mk(4'h3, 2'b00, 2'd0, 2'd2, 2'd1, 8'h00), w);
        wait_idle();
        reg_is("sub_r0", 2'd0, 8'h82);
        chk("sub_flags", 32'(FLAGS), 32'b1010);

        // NOP and unused opcode: no side effects
        send(mk(4'hF, 2'b00, 2'd0, 2'd1, 2'd2, 8'h11), w);
        send(mk(4'h0, 2'b00, 2'd0, 2'd1, 2'd2, 8'h22), w);
        chk("nop_busy", 32'(BUSY), 32'd0);
        reg_is("nop_r0", 2'd0, 8'h82);
        chk("nop_flags", 32'(FLAGS), 32'b1010);

        // Three queued ALU ops offered back-to-back while busy
        send(mk(4'h1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h0C), w);
        send(mk(4'h1, 2'b00, 2'd2, 2'd0, 2'd0, 8'h0A), w);
        send(mk(4'h6, 2'b00, 2'd3, 2'd1, 2'd2, 8'h00), w);
        chk("q1_ready_low", 32'(INSTR_READY), 32'd0);
        send(mk(4'h5, 2'b00, 2'd0, 2'd3, 2'd1, 8'h00), w);
        chk("q2_wait", 32'(w), 32'd2);
        send(mk(4'h3, 2'b00, 2'd1, 2'd0, 2'd2, 8'h00), w);
        chk("q3_wait", 32'(w), 32'd2);
        wait_idle();
        reg_is("q_r3", 2'd3, 8'h06);
        reg_is("q_r0", 2'd0, 8'h0E);
        reg_is("q_r1", 2'd1, 8'h04);
        chk("q_flags", 32'(FLAGS), 32'b0000);

        // Reset in WB abandons the op
        send(mk(4'h1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h0F), w);
        send(mk(4'h1, 2'b00, 2'd2, 2'd0, 2'd0, 8'h33), w);
        send(mk(4'h4, 2'b00, 2'd0, 2'd1, 2'd2, 8'h00), w);
        @(negedge CLK);
        chk("pre_rst_wb", 32'({ALU_EN, ALU_OE}), 32'b11);
        RST = 1'b1;
        #1;
        chk("rst_pulse_ready", 32'(INSTR_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        reg_is("wbrst_r0", 2'd0, 8'h00);
        chk("wbrst_flags", 32'(FLAGS), 32'b0000);
        chk("wbrst_busy", 32'(BUSY), 32'd0);
        chk("wbrst_en_oe", 32'({ALU_EN, ALU_OE}), 32'b00);
        chk("wbrst_ready", 32'(INSTR_READY), 32'd1);
        @(negedge CLK);

        // Conditional execution after a zero result
        send(mk(4'h1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h10), w);
        send(mk(4'h3, 2'b00, 2'd0, 2'd1, 2'd1, 8'h00), w);
        wait_idle();
        chk("zf_flags", 32'(FLAGS), 32'b0100);
        send(mk(4'h1, 2'b10, 2'd1, 2'd0, 2'd0, 8'hAA), w);
`ifdef COND_EXEC_EN
        reg_is("cond_nz_skip", 2'd1, 8'h10);
`else
        reg_is("cond_ignored", 2'd1, 8'hAA);
`endif
        send(mk(4'h1, 2'b01, 2'd1, 2'd0, 2'd0, 8'h55), w);
        reg_is("cond_z_exec", 2'd1, 8'h55);
        chk("cond_flags", 32'(FLAGS), 32'b0100);

        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
